// File: rtl/approx_serial_adder.sv
// Bit-serial LSB-first adder: OR approximation on the low APPROX_BITS positions, exact
// ripple with a registered carry above, plus an exact reference sum for error flagging.
module approx_serial_adder #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned APPROX_BITS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             err,
   output logic             busy
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned SW = WIDTH + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] a_sh, b_sh, res, res_next;
   logic [SW-1:0]    exact;
   logic [CW-1:0]    cnt;
   logic             carry, carry_next, sum_bit, approx_bit;
   logic             accept, step, last_bit, done_ack;

   assign in_ready = (state == IDLE) & ~rst;
   assign busy     = (state != IDLE);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state and control decode
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      step       = 1'b0;
      last_bit   = 1'b0;
      done_ack   = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
               last_bit   = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_valid & out_ready) begin
               done_ack   = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // One-bit cell: OR/AND below the approximation boundary, full add above it
   always_comb begin
      approx_bit = (32'(cnt) < APPROX_BITS);
      if (approx_bit) begin
         sum_bit    = a_sh[0] | b_sh[0];
         carry_next = a_sh[0] & b_sh[0];
      end else begin
         sum_bit    = a_sh[0] ^ b_sh[0] ^ carry;
         carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
      end
      res_next = {sum_bit, res[WIDTH-1:1]};
   end

   // Serial datapath and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh      <= '0;
         b_sh      <= '0;
         res       <= '0;
         exact     <= '0;
         cnt       <= '0;
         carry     <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         err       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            exact <= SW'(a) + SW'(b) + SW'(cin);
            cnt   <= '0;
            carry <= (APPROX_BITS == 0) ? cin : 1'b0;
         end
         if (step) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            res   <= res_next;
            carry <= carry_next;
            cnt   <= cnt + CW'(1);
         end
         if (last_bit) begin
            sum       <= res_next;
            cout      <= carry_next;
            err       <= ({carry_next, res_next} != exact);
            out_valid <= 1'b1;
         end
         if (done_ack) out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_approx_serial_adder.sv
// Bench for approx_serial_adder: three instances (APPROX_BITS = 4, 0, 8) checked
// against an arithmetic model of the OR-lower / exact-upper rule.
module tb_approx_serial_adder;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] a, b;
   logic         cin, out_ready;
   logic [2:0]   iv, ir, ov, co, er, bz;
   logic [W-1:0] s0, s1, s2;
   int           sel;
   int           passed = 0;
   int           total  = 0;

   logic         c_ready, c_valid, c_cout, c_err, c_busy;
   logic [W-1:0] c_sum;

   always #5 clk = ~clk;

   approx_serial_adder #(.WIDTH(W), .APPROX_BITS(4)) u_a4 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a), .b(b), .cin(cin),
      .out_valid(ov[0]), .out_ready(out_ready), .sum(s0), .cout(co[0]), .err(er[0]), .busy(bz[0]));
   approx_serial_adder #(.WIDTH(W), .APPROX_BITS(0)) u_a0 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a), .b(b), .cin(cin),
      .out_valid(ov[1]), .out_ready(out_ready), .sum(s1), .cout(co[1]), .err(er[1]), .busy(bz[1]));
   approx_serial_adder #(.WIDTH(W), .APPROX_BITS(8)) u_a8 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a), .b(b), .cin(cin),
      .out_valid(ov[2]), .out_ready(out_ready), .sum(s2), .cout(co[2]), .err(er[2]), .busy(bz[2]));

   assign c_ready = ir[sel];
   assign c_valid = ov[sel];
   assign c_cout  = co[sel];
   assign c_err   = er[sel];
   assign c_busy  = bz[sel];
   assign c_sum   = (sel == 0) ? s0 : (sel == 1) ? s1 : s2;

   function automatic int approx_of(input int k);
      return (k == 0) ? 4 : (k == 1) ? 0 : 8;
   endfunction

   // Low part: plain OR; upper part: ordinary addition of the upper slices with
   // the carry generated by the top approximate position (or cin when exact).
   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic ci, input int ab);
      int xi, yi, low, c, up;
      xi  = int'(x);
      yi  = int'(y);
      low = (xi | yi) & ((1 << ab) - 1);
      c   = (ab == 0) ? int'(ci) : ((xi >> (ab - 1)) & (yi >> (ab - 1)) & 1);
      up  = (xi >> ab) + (yi >> ab) + c;
      return (W + 1)'((up << ab) | low);
   endfunction

   function automatic logic [W:0] exact_of(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
      return (W + 1)'(int'(x) + int'(y) + int'(ci));
   endfunction

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         input logic [W:0] exp_res, input logic exp_err, input string name);
      int lat;
      @(negedge clk);
      a = ta; b = tb_; cin = tc; iv[sel] = 1'b1;
      total++;
      if (c_ready !== 1'b1) $display("FAIL %s in_ready before accept: got %b want 1", name, c_ready);
      else passed++;
      @(posedge clk); #1;
      iv = '0;
      lat = 0;
      while (c_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      total++;
      if (lat !== int'(W)) $display("FAIL %s latency: got %0d want %0d", name, lat, W);
      else passed++;
      total++;
      if ({c_cout, c_sum} !== exp_res) $display("FAIL %s result: got %h want %h", name, {c_cout, c_sum}, exp_res);
      else passed++;
      total++;
      if (c_err !== exp_err) $display("FAIL %s err: got %b want %b", name, c_err, exp_err);
      else passed++;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (c_valid !== 1'b0 || c_busy !== 1'b0 || c_ready !== 1'b1)
         $display("FAIL %s release: got valid=%b busy=%b ready=%b want 0 0 1", name, c_valid, c_busy, c_ready);
      else passed++;
   endtask

   task automatic run_random(input int n, input string name);
      logic [W-1:0] ra, rb;
      logic         rc;
      logic [W:0]   m;
      for (int i = 0; i < n; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         m  = model(ra, rb, rc, approx_of(sel));
         run_op(ra, rb, rc, m, (m != exact_of(ra, rb, rc)), name);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; iv = '0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (ir !== 3'b000 || ov !== 3'b000 || bz !== 3'b000 || co !== 3'b000 || er !== 3'b000 ||
          s0 !== '0 || s1 !== '0 || s2 !== '0)
         $display("FAIL reset_state: got ir=%b ov=%b bz=%b co=%b er=%b s=%h/%h/%h want all 0",
                  ir, ov, bz, co, er, s0, s1, s2);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      total++;
      if (ir !== 3'b111) $display("FAIL reset_release in_ready: got %b want 111", ir);
      else passed++;
   endtask

   task automatic test_approx_plan();
      sel = 0;
      run_op(8'h12, 8'h21, 1'b0, 9'h033, 1'b0, "a4_12_21");
      run_op(8'h0F, 8'h01, 1'b0, 9'h00F, 1'b1, "a4_0F_01");
      run_op(8'hF8, 8'h08, 1'b0, 9'h108, 1'b1, "a4_F8_08");
      run_random(8, "a4_rand");
   endtask

   task automatic test_exact();
      sel = 1;
      run_op(8'hFF, 8'h01, 1'b1, 9'h101, 1'b0, "a0_FF_01_c1");
      run_op(8'h55, 8'hAA, 1'b0, 9'h0FF, 1'b0, "a0_55_AA");
      run_random(6, "a0_rand");
   endtask

   task automatic test_full_approx();
      sel = 2;
      run_op(8'h80, 8'h80, 1'b0, 9'h180, 1'b1, "a8_80_80");
      run_op(8'h0F, 8'h70, 1'b1, 9'h07F, 1'b1, "a8_0F_70_c1");
      run_random(6, "a8_rand");
   endtask

   task automatic test_backpressure();
      int lat;
      sel = 0;
      @(negedge clk);
      a = 8'h0F; b = 8'h01; cin = 1'b0; iv[0] = 1'b1;
      @(posedge clk); #1;
      iv = '0;
      lat = 0;
      while (c_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      total++;
      if (lat !== int'(W)) $display("FAIL bp latency: got %0d want %0d", lat, W);
      else passed++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         iv[0] = 1'(i % 2 == 0);
         @(posedge clk); #1;
         total++;
         if (c_valid !== 1'b1 || c_ready !== 1'b0 || {c_cout, c_sum} !== 9'h00F || c_err !== 1'b1)
            $display("FAIL bp_hold cycle %0d: got valid=%b ready=%b res=%h err=%b want 1 0 00f 1",
                     i, c_valid, c_ready, {c_cout, c_sum}, c_err);
         else passed++;
      end
      @(negedge clk);
      iv = '0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (c_valid !== 1'b0 || c_ready !== 1'b1)
         $display("FAIL bp_release: got valid=%b ready=%b want 0 1", c_valid, c_ready);
      else passed++;
      run_op(8'h12, 8'h21, 1'b0, 9'h033, 1'b0, "bp_next");
   endtask

   task automatic test_reset_mid_run();
      sel = 0;
      @(negedge clk);
      a = 8'hF8; b = 8'h08; cin = 1'b0; iv[0] = 1'b1;
      @(posedge clk); #1;
      iv = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      total++;
      if (c_valid !== 1'b0 || c_busy !== 1'b0 || c_sum !== '0 || c_cout !== 1'b0 ||
          c_err !== 1'b0 || c_ready !== 1'b0)
         $display("FAIL mid_run_reset: got valid=%b busy=%b sum=%h cout=%b err=%b ready=%b want all 0",
                  c_valid, c_busy, c_sum, c_cout, c_err, c_ready);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      run_op(8'h0F, 8'h01, 1'b0, 9'h00F, 1'b1, "after_reset");
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] pa [4];
      logic [W-1:0] pb [4];
      logic         pc [4];
      int           acc_cyc [4];
      int           res_cyc [4];
      int           cyc, n_acc, n_res;
      logic         acc_now;
      logic [W:0]   m;
      sel = 0;
      for (int i = 0; i < 4; i++) begin
         pa[i] = W'($urandom);
         pb[i] = W'($urandom);
         pc[i] = 1'($urandom);
      end
      cyc = 0; n_acc = 0; n_res = 0;
      out_ready = 1'b1;
      while (n_res < 4 && cyc < 200) begin
         @(negedge clk);
         if (n_acc < 4) begin
            a = pa[n_acc]; b = pb[n_acc]; cin = pc[n_acc]; iv[0] = 1'b1;
         end else begin
            iv = '0;
         end
         acc_now = c_ready & iv[0];
         @(posedge clk); #1;
         cyc++;
         if (acc_now) begin
            acc_cyc[n_acc] = cyc;
            n_acc++;
         end
         if (c_valid === 1'b1) begin
            m = model(pa[n_res], pb[n_res], pc[n_res], 4);
            res_cyc[n_res] = cyc;
            total++;
            if ({c_cout, c_sum} !== m || c_err !== (m != exact_of(pa[n_res], pb[n_res], pc[n_res])))
               $display("FAIL b2b result %0d: got %h err=%b want %h err=%b", n_res, {c_cout, c_sum},
                        c_err, m, (m != exact_of(pa[n_res], pb[n_res], pc[n_res])));
            else passed++;
            n_res++;
         end
      end
      iv = '0;
      out_ready = 1'b0;
      total++;
      if (n_res !== 4 || n_acc !== 4) $display("FAIL b2b counts: got acc=%0d res=%0d want 4 4", n_acc, n_res);
      else passed++;
      for (int i = 0; i < n_res; i++) begin
         total++;
         if (res_cyc[i] - acc_cyc[i] !== int'(W))
            $display("FAIL b2b latency %0d: got %0d want %0d", i, res_cyc[i] - acc_cyc[i], W);
         else passed++;
         if (i > 0) begin
            total++;
            if (acc_cyc[i] - acc_cyc[i-1] !== int'(W) + 2)
               $display("FAIL b2b spacing %0d: got %0d want %0d", i, acc_cyc[i] - acc_cyc[i-1], W + 2);
            else passed++;
         end
      end
   endtask

   initial begin
      sel = 0;
      test_reset();
      test_approx_plan();
      test_exact();
      test_full_approx();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
